// File: rtl/sysbus_arbiter.sv
// Two-client Sysbus arbiter: client 0 is the instruction cache, client 1 the
// data cache. Round-robin bid/grant; a grant is held for one complete bus
// transaction (request beats, then RESP_BEATS response beats for reads).
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   cN_bid / cN_grant            per-client bus request / registered grant
//   cN_reqcyc, cN_req, cN_reqtag client request beat (forwarded when granted)
//   cN_respack                   client accepts a response beat
//   cN_reqack, cN_respcyc        bus handshakes routed to the granted client
//   c_resp, c_resptag            bus response broadcast to both clients
//   bus_*                        Sysbus master port
module sysbus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned RESP_BEATS     = 8,
    parameter int unsigned WR_TAG_BIT     = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c0_bid,
    input  logic                      c1_bid,
    output logic                      c0_grant,
    output logic                      c1_grant,
    input  logic                      c0_reqcyc,
    input  logic                      c1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    input  logic                      c0_respack,
    input  logic                      c1_respack,
    output logic                      c0_reqack,
    output logic                      c1_reqack,
    output logic                      c0_respcyc,
    output logic                      c1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c_resptag,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int unsigned CNT_WIDTH = $clog2(RESP_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   prio_q, prio_d;        // client that wins a tie
    logic                   is_write_q, is_write_d;
    logic                   req_seen_q, req_seen_d;  // is_write already latched
    logic                   beat_done_q, beat_done_d; // >=1 request beat accepted
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   rel;

    // Granted client's signals; all zero when no grant or in reset.
    logic                      g_bid;
    logic                      g_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] g_req;
    logic [BUS_TAG_WIDTH-1:0]  g_tag;
    logic                      g_respack;

    always_comb begin
        g_bid     = 1'b0;
        g_reqcyc  = 1'b0;
        g_req     = '0;
        g_tag     = '0;
        g_respack = 1'b0;
        if (reset && grant_q[0]) begin
            g_bid     = c0_bid;
            g_reqcyc  = c0_reqcyc;
            g_req     = c0_req;
            g_tag     = c0_reqtag;
            g_respack = c0_respack;
        end else if (reset && grant_q[1]) begin
            g_bid     = c1_bid;
            g_reqcyc  = c1_reqcyc;
            g_req     = c1_req;
            g_tag     = c1_reqtag;
            g_respack = c1_respack;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        is_write_d  = is_write_q;
        req_seen_d  = req_seen_q;
        beat_done_d = beat_done_q;
        cnt_d       = cnt_q;
        rel         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (c0_bid || c1_bid) begin
                    grant_d     = (c0_bid && (!c1_bid || !prio_q)) ? 2'b01 : 2'b10;
                    state_d     = StReq;
                    req_seen_d  = 1'b0;
                    beat_done_d = 1'b0;
                end
            end
            StReq: begin
                if (g_reqcyc && !req_seen_q) begin
                    is_write_d = g_tag[WR_TAG_BIT];
                    req_seen_d = 1'b1;
                end
                if (g_reqcyc && bus_reqack) begin
                    beat_done_d = 1'b1;
                end
                if (!g_reqcyc && beat_done_q) begin
                    if (is_write_q) begin
                        rel = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
                end else if (!g_bid && !beat_done_q && !(g_reqcyc && bus_reqack)) begin
                    // Bid withdrawn before anything reached the bus.
                    rel = 1'b1;
                end
            end
            StResp: begin
                if (bus_respcyc && g_respack) begin
                    if (cnt_q == CNT_WIDTH'(RESP_BEATS - 1)) begin
                        cnt_d = '0;
                        rel   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (rel) begin
            state_d = StIdle;
            grant_d = 2'b00;
            prio_d  = grant_q[0];  // the other client gets the next tie
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= 2'b00;
            prio_q      <= 1'b0;
            is_write_q  <= 1'b0;
            req_seen_q  <= 1'b0;
            beat_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            is_write_q  <= is_write_d;
            req_seen_q  <= req_seen_d;
            beat_done_q <= beat_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign c0_grant    = grant_q[0];
    assign c1_grant    = grant_q[1];
    assign bus_reqcyc  = g_reqcyc;
    assign bus_req     = g_req;
    assign bus_reqtag  = g_tag;
    assign bus_respack = g_respack;
    assign c0_reqack   = reset & grant_q[0] & bus_reqack;
    assign c1_reqack   = reset & grant_q[1] & bus_reqack;
    assign c0_respcyc  = reset & grant_q[0] & bus_respcyc;
    assign c1_respcyc  = reset & grant_q[1] & bus_respcyc;
    assign c_resp      = bus_resp;
    assign c_resptag   = bus_resptag;

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;
    localparam int WRB   = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    bid, reqcyc, respack;
    logic [1:0]    grant, reqack_o, respcyc_o;
    logic [DW-1:0] req [2];
    logic [TW-1:0] reqtag [2];
    logic          bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [DW-1:0] bus_req, bus_resp, c_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag, c_resptag;

    int errors = 0;
    int checks = 0;
    int last_owner = 1;  // model: client granted last; 1 so that client 0 wins first tie

    sysbus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .c0_bid     (bid[0]),
        .c1_bid     (bid[1]),
        .c0_grant   (grant[0]),
        .c1_grant   (grant[1]),
        .c0_reqcyc  (reqcyc[0]),
        .c1_reqcyc  (reqcyc[1]),
        .c0_req     (req[0]),
        .c1_req     (req[1]),
        .c0_reqtag  (reqtag[0]),
        .c1_reqtag  (reqtag[1]),
        .c0_respack (respack[0]),
        .c1_respack (respack[1]),
        .c0_reqack  (reqack_o[0]),
        .c1_reqack  (reqack_o[1]),
        .c0_respcyc (respcyc_o[0]),
        .c1_respcyc (respcyc_o[1]),
        .c_resp     (c_resp),
        .c_resptag  (c_resptag),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_respack(bus_respack),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bid         = 2'b00;
        reqcyc      = 2'b00;
        respack     = 2'b00;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset       = 1'b0;
        bid         = 2'b11;
        reqcyc      = 2'b11;
        respack     = 2'b11;
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = rnd64();
        bus_resptag = TW'($urandom);
        for (int i = 0; i < 2; i++) begin
            req[i]    = rnd64();
            reqtag[i] = TW'($urandom);
        end
        tick();
        tick();
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant: got %b want 00", grant);
        end
        checks++;
        if ({bus_reqcyc, bus_respack, reqack_o, respcyc_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b want 000000",
                     {bus_reqcyc, bus_respack, reqack_o, respcyc_o});
        end
        checks++;
        if (bus_req !== '0 || bus_reqtag !== '0) begin
            errors++; $display("FAIL reset_bus_data: got %h/%h want 0/0", bus_req, bus_reqtag);
        end
        checks++;
        if (c_resp !== bus_resp || c_resptag !== bus_resptag) begin
            errors++;
            $display("FAIL resp_broadcast: got %h/%h want %h/%h",
                     c_resp, c_resptag, bus_resp, bus_resptag);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL idle_no_bid: got %b want 00", grant);
        end
    endtask

    // Both bid continuously; short write transactions from each winner.
    task automatic test_round_robin();
        int w;
        logic [1:0] exp_g;
        bid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            tick();
            w = 1 - last_owner;
            exp_g = 2'b00;
            exp_g[w] = 1'b1;
            checks++;
            if (grant !== exp_g) begin
                errors++; $display("FAIL rr_grant%0d: got %b want %b", n, grant, exp_g);
            end
            reqcyc[w] = 1'b1;
            req[w]    = rnd64();
            reqtag[w] = TW'($urandom) | (TW'(1) << WRB);
            bus_reqack = 1'b1;
            #1;
            checks++;
            if (bus_reqcyc !== 1'b1 || bus_req !== req[w] || bus_reqtag !== reqtag[w]) begin
                errors++;
                $display("FAIL rr_mux%0d: got %b/%h want 1/%h", n, bus_reqcyc, bus_req, req[w]);
            end
            tick();
            reqcyc[w]  = 1'b0;
            bus_reqack = 1'b0;
            if (n == 3) bid = 2'b00;
            checks++;
            if (grant !== exp_g) begin
                errors++; $display("FAIL rr_hold%0d: got %b want %b", n, grant, exp_g);
            end
            tick();
            checks++;
            if (grant !== 2'b00) begin
                errors++; $display("FAIL rr_gap%0d: got %b want 00", n, grant);
            end
            last_owner = w;
        end
    endtask

    // Read: request beat(s), then BEATS acknowledged response beats.
    // stall3 forces three respcyc-without-respack cycles after beat 3.
    task automatic test_read(input int who, input bit stall3);
        int o;
        int acked;
        int stalls;
        int cyc;
        bit done;
        logic ack;
        logic [1:0] exp_g;
        logic [1:0] exp_rc;
        o = 1 - who;
        idle_inputs();
        bid[who] = 1'b1;
        tick();
        exp_g = 2'b00;
        exp_g[who] = 1'b1;
        checks++;
        if (grant !== exp_g) begin
            errors++; $display("FAIL rd_grant: got %b want %b", grant, exp_g);
        end
        reqcyc[who] = 1'b1;
        req[who]    = rnd64();
        reqtag[who] = TW'($urandom) & ~(TW'(1) << WRB);
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            bus_reqack = (c > 0) || ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (bus_req !== req[who] || bus_reqtag !== reqtag[who] ||
                reqack_o[who] !== bus_reqack || reqack_o[o] !== 1'b0) begin
                errors++;
                $display("FAIL rd_req_mux: got %h/%b want %h/%b",
                         bus_req, reqack_o, req[who], exp_g & {2{bus_reqack}});
            end
            tick();
            if (bus_reqack) done = 1'b1;
        end
        reqcyc[who] = 1'b0;
        bus_reqack  = 1'b0;
        bid[who]    = 1'b0;  // withdrawn bid must not end the burst
        tick();
        checks++;
        if (grant !== exp_g) begin
            errors++; $display("FAIL rd_enter_resp: got %b want %b", grant, exp_g);
        end
        reqcyc[o]  = 1'b1;
        respack[o] = 1'b1;
        acked  = 0;
        stalls = 0;
        cyc    = 0;
        while (acked < BEATS && cyc < 80) begin
            if (stall3) begin
                bus_respcyc = 1'b1;
                ack = !(acked == 3 && stalls < 3);
                if (!ack) stalls++;
            end else begin
                bus_respcyc = ($urandom_range(0, 4) != 0);
                ack = ($urandom_range(0, 3) != 0);
            end
            respack[who] = ack;
            bus_resp     = rnd64();
            bus_resptag  = TW'($urandom);
            #1;
            exp_rc = 2'b00;
            exp_rc[who] = bus_respcyc;
            checks++;
            if (respcyc_o !== exp_rc || bus_respack !== ack || bus_reqcyc !== 1'b0) begin
                errors++;
                $display("FAIL rd_resp_route: got rc=%b ack=%b rq=%b want rc=%b ack=%b rq=0",
                         respcyc_o, bus_respack, bus_reqcyc, exp_rc, ack);
            end
            checks++;
            if (c_resp !== bus_resp) begin
                errors++; $display("FAIL rd_resp_data: got %h want %h", c_resp, bus_resp);
            end
            tick();
            if (bus_respcyc && ack) acked++;
            cyc++;
            exp_g = 2'b00;
            if (acked < BEATS) exp_g[who] = 1'b1;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rd_grant_beat%0d: got %b want %b", acked, grant, exp_g);
            end
        end
        last_owner = who;
        idle_inputs();
    endtask

    // c1 write: 4 beats, reqack stalled 2 cycles mid-burst, no response phase.
    task automatic test_write_c1();
        bit stall;
        idle_inputs();
        bid[1] = 1'b1;
        reqcyc[0]  = 1'b1;  // ungranted client traffic must stay off the bus
        req[0]     = rnd64();
        respack[0] = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            errors++; $display("FAIL wr_grant: got %b want 10", grant);
        end
        reqcyc[1] = 1'b1;
        req[1]    = rnd64();
        reqtag[1] = TW'($urandom) | (TW'(1) << WRB);
        for (int c = 0; c < 6; c++) begin
            stall = (c == 2 || c == 3);
            bus_reqack = !stall;
            #1;
            checks++;
            if (bus_reqcyc !== 1'b1 || bus_req !== req[1] || bus_reqtag !== reqtag[1] ||
                reqack_o !== {bus_reqack, 1'b0} || bus_respack !== 1'b0) begin
                errors++;
                $display("FAIL wr_beat%0d: got %h/%b/%b want %h/%b/0",
                         c, bus_req, reqack_o, bus_respack, req[1], {bus_reqack, 1'b0});
            end
            tick();
            checks++;
            if (grant !== 2'b10) begin
                errors++; $display("FAIL wr_hold%0d: got %b want 10", c, grant);
            end
            if (bus_reqack) req[1] = rnd64();
        end
        reqcyc[1]  = 1'b0;
        bus_reqack = 1'b0;
        bid[1]     = 1'b0;
        tick();
        checks++;
        if (grant !== 2'b00 || bus_respack !== 1'b0) begin
            errors++; $display("FAIL wr_release: got %b/%b want 00/0", grant, bus_respack);
        end
        last_owner = 1;
        idle_inputs();
    endtask

    // c0 bids 2 cycles without reqcyc; pending c1 bid is served afterwards.
    task automatic test_abort();
        idle_inputs();
        bid[0] = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL ab_grant: got %b want 01", grant);
        end
        bid[1] = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL ab_hold: got %b want 01", grant);
        end
        bid[0] = 1'b0;
        tick();
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL ab_release: got %b want 00", grant);
        end
        last_owner = 0;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            errors++; $display("FAIL ab_pending: got %b want 10", grant);
        end
        reqcyc[1]  = 1'b1;
        reqtag[1]  = TW'(1) << WRB;
        bus_reqack = 1'b1;
        tick();
        reqcyc[1]  = 1'b0;
        bus_reqack = 1'b0;
        bid[1]     = 1'b0;
        tick();
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL ab_c1_done: got %b want 00", grant);
        end
        last_owner = 1;
    endtask

    // Reset asserted during response beat 5, then a fresh c1 read.
    task automatic test_reset_mid();
        idle_inputs();
        bid[0] = 1'b1;
        tick();
        reqcyc[0]  = 1'b1;
        req[0]     = rnd64();
        reqtag[0]  = TW'(0);
        bus_reqack = 1'b1;
        tick();
        reqcyc[0]  = 1'b0;
        bus_reqack = 1'b0;
        bid[0]     = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_respcyc = 1'b1;
            respack[0]  = 1'b1;
            tick();
        end
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL rm_before: got %b want 01", grant);
        end
        reqcyc[0]  = 1'b1;
        bus_reqack = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || {bus_reqcyc, bus_respack, reqack_o, respcyc_o} !== 6'b0 ||
            bus_req !== '0 || bus_reqtag !== '0) begin
            errors++;
            $display("FAIL rm_async: got g=%b hs=%b req=%h want g=00 hs=000000 req=0", grant,
                     {bus_reqcyc, bus_respack, reqack_o, respcyc_o}, bus_req);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        last_owner = 1;
        tick();
        test_read(1, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_read(0, 1'b0);
        test_write_c1();
        test_read(0, 1'b1);
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between two clients: client 0 is the instruction cache and client 1 is the data cache.
- Per-client bid/grant handshake with round-robin fairness.
- Once a client is granted, the arbiter holds the grant for one complete bus transaction: request phase, then the response burst for reads.
- Muxes the granted client's request signals onto the bus and routes response handshakes back to that client only.

Parameters:
- BUS_DATA_WIDTH, 64, width of req/resp data.
- BUS_TAG_WIDTH, 13, width of req/resp tags.
- RESP_BEATS, 8, response beats per read transaction (one cache line).
- WR_TAG_BIT, 12, reqtag bit that marks a write. Writes have no response phase.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- c0_bid, c1_bid  input  1 each  client requests the bus.
- c0_grant, c1_grant  output  1 each  client owns the bus; registered.
- c0_reqcyc, c1_reqcyc  input  1 each  client request valid.
- c0_req, c1_req  input  BUS_DATA_WIDTH each  client request data.
- c0_reqtag, c1_reqtag  input  BUS_TAG_WIDTH each  client request tag.
- c0_respack, c1_respack  input  1 each  client accepts a response beat.
- c0_reqack, c1_reqack  output  1 each  bus_reqack gated by grant.
- c0_respcyc, c1_respcyc  output  1 each  bus_respcyc gated by grant.
- c_resp  output  BUS_DATA_WIDTH  bus_resp broadcast to both clients.
- c_resptag  output  BUS_TAG_WIDTH  bus_resptag broadcast to both clients.
- bus_reqcyc  output  1  request valid to the bus.
- bus_req  output  BUS_DATA_WIDTH  request data to the bus.
- bus_reqtag  output  BUS_TAG_WIDTH  request tag to the bus.
- bus_respack  output  1  response-beat acknowledge to the bus.
- bus_reqack  input  1  bus accepts a request beat.
- bus_respcyc  input  1  response beat valid from the bus.
- bus_resp  input  BUS_DATA_WIDTH  response data from the bus.
- bus_resptag  input  BUS_TAG_WIDTH  response tag from the bus.

Behaviour:
- Reset (reset==0, asynchronous) clears:
  - state to IDLE, both grants to 0, beat count to 0;
  - round-robin pointer so that client 0 has priority;
  - is_write to 0.
- While reset is low, or no grant is held, these outputs are 0: bus_reqcyc, bus_req, bus_reqtag, bus_respack, c0/c1_reqack, c0/c1_respcyc.
- Output muxing is combinational from the registered grant. An ungranted client's reqcyc and respack are ignored.
- States:
  - IDLE: if any bid is asserted, register the winner's grant; next state is REQ. Grant is visible the cycle after the bid is first sampled.
    - Both clients bidding: the winner is the client not granted last time; after reset, client 0.
    - Single bidder: wins immediately.
  - REQ:
    - On the first cycle with the granted reqcyc high, latch is_write = reqtag[WR_TAG_BIT].
    - A beat is accepted when reqcyc && bus_reqack.
    - When reqcyc is low and at least one beat has been accepted: go to RESP if is_write==0, else release the bus.
    - If bid drops before any beat is accepted: release the bus (aborted bid).
  - RESP:
    - A beat counts when bus_respcyc && granted respack.
    - Beat count width is $clog2(RESP_BEATS+1).
    - On the RESP_BEATS-th counted beat: release the bus and clear the count.
    - Extra bus_respcyc cycles without respack are not counted; hold state.
- Release: the grant goes low the next cycle, state returns to IDLE, and the round-robin pointer moves to the other client.
- There is no back-to-back grant in the release cycle: at least one IDLE cycle separates two grants.
- The arbiter never grants both clients; one-hot-or-zero is an invariant.
- Bid withdrawn during RESP is ignored; the grant is held until the burst completes.
- Reset asserted mid-transaction aborts immediately. Outputs are zero within the same cycle, asynchronously.

Test Plan:
- Reset, then c0_bid=1 only: c0_grant=1 on the next edge. Read with reqtag[12]=0, 1 request beat acked, 8 respcyc/respack beats. c0_grant drops the cycle after beat 8.
- c0_bid and c1_bid both high continuously: grants alternate 0,1,0,1 with exactly one IDLE cycle between them. c1_grant is never high while c0_grant is high.
- c1 write with reqtag[12]=1: 4 request beats with reqack stalled 2 cycles mid-burst. Release follows the reqcyc drop; there is no RESP phase and bus_respack stays 0.
- During RESP, bus_respcyc=1 with c0_respack=0 for 3 cycles: count holds. Grant ends only after 8 acknowledged beats. Meanwhile c1_respcyc stays 0 and c1's reqcyc is not forwarded.
- c0_bid pulses for 2 cycles with no reqcyc: grant then release back to IDLE. Pending c1_bid is granted afterwards.
- reset driven low at RESP beat 5: all grants and bus outputs are 0 immediately. After release, a fresh c1-only bid completes normally with the count restarting from 0.
